alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (operand pair plus execmd_t command in, WORD_LEN result out) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Drives the shared ALU inputs and captures the ALU result into a single-entry response register, tagged with the requester ID.
- Sits between the issue stages of multiple clients and the execute datapath; the ALU itself is instantiated outside this block.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_val1  input  NUM_REQ*WORD_LEN  operand 1 per requester, requester i at bits [i*WORD_LEN +: WORD_LEN].
- req_val2  input  NUM_REQ*WORD_LEN  operand 2 per requester, same packing.
- req_cmd  input  execmd_t [NUM_REQ]  command per requester.
- alu_val1  output  WORD_LEN  to shared ALU val1.
- alu_val2  output  WORD_LEN  to shared ALU val2.
- alu_cmd  output  execmd_t  to shared ALU EXE_CMD.
- alu_out  input  WORD_LEN  from shared ALU aluout.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WORD_LEN  registered ALU result.
- rsp_id  output  ID_W  index of the requester that issued the result.
- flush  input  1  synchronous discard of the pending response.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - rr_ptr=0; FSM goes to EMPTY.
  - req_ready=0 while rst_n=0.
- FSM states:
  - EMPTY: response register invalid.
  - FULL: response register holds an undrained result.
- can_accept = (state==EMPTY) || (rsp_valid && rsp_ready). This allows a back-to-back result every cycle.
- Arbitration is combinational:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner g.
  - req_ready[g] = can_accept && !flush; all other req_ready bits are 0.
  - No valid requests means no grant.
- ALU drive:
  - With a winner: alu_val1/alu_val2/alu_cmd = the winner's operands and command.
  - With no winner: alu_val1=0, alu_val2=0, alu_cmd=EXE_ADD.
  - The winner's operands and command are muxed to the ALU in the same cycle.
- Transfer: a transfer occurs when req_valid[g] && req_ready[g]. On that edge:
  - rsp_data <= alu_out, rsp_id <= g, state <= FULL.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle: accept at edge N, rsp_valid high after edge N.
- Drain:
  - rsp_valid && rsp_ready with no new transfer: state <= EMPTY.
  - With a simultaneous new transfer: stay FULL and load the new data.
- Hold: in FULL with rsp_ready=0, rsp_data/rsp_id are stable and all req_ready are 0.
- Requester rules:
  - A requester holds req_valid and its operands stable until accepted.
  - req_ready may depend combinationally on req_valid.
- Unknown commands are passed through unchanged; the ALU returns 0 for them, and the arbiter does not check.
- flush=1 at an edge:
  - state <= EMPTY, rsp_valid <= 0.
  - No transfer that cycle, because req_ready is forced to 0.
  - rr_ptr is unchanged.
- flush and rst_n together: reset wins.
- Starvation bound: a continuously valid requester is granted within NUM_REQ accepts.

Optional Feature:
- ALU_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQ].
  - If the transferring requester g has req_lock[g]=1, rr_ptr <= g, so g keeps top priority. This lets it issue back-to-back dependent operations.
  - The lock is sampled only on transfer edges.
  - A requester that deasserts req_valid loses priority naturally.
- Undefined:
  - The port is absent.
  - rr_ptr always advances to g+1.

Test Plan:
- Reset: hold rst_n=0 two cycles with all req_valid=1 -> rsp_valid=0, req_ready=0. First grant after release goes to requester 0.
- Single op: requester 2 issues EXE_SUB, val1=10, val2=3, rsp_ready=1 -> req_ready[2]=1 that cycle. Next cycle rsp_valid=1, rsp_data=7, rsp_id=2.
- Round-robin: all four requesters valid with EXE_ADD on distinct operands, rsp_ready=1 -> grants in order 0,1,2,3,0. One result per cycle with matching rsp_id.
- Backpressure: fill the response register with rsp_ready=0 for 3 cycles -> req_ready all 0 and rsp_data stable. Raising rsp_ready drains and accepts the next request in the same cycle.
- Flush: FULL state, assert flush with req_valid[1]=1 -> next cycle rsp_valid=0. Requester 1 is accepted the cycle after flush drops, and rr_ptr is unaffected.
- Lock (ALU_ARB_LOCK_EN): requesters 0 and 1 valid, req_lock[0]=1 -> requester 0 is granted three consecutive times. Dropping the lock -> requester 1 is granted next.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU between requesters
//
// Purpose:
//   Picks one of NUM_REQ requesters per cycle (round-robin, valid/ready), muxes its
//   operands and command onto the shared ALU, and captures the ALU result into a
//   single-entry response register tagged with the requester index.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake (at most one ready bit high)
//   req_val1/req_val2     packed operands, requester i at [i*WORD_LEN +: WORD_LEN]
//   req_cmd               per-requester ALU command
//   req_lock              (ALU_ARB_LOCK_EN only) keep priority after a transfer
//   alu_val1/2, alu_cmd   drive to the shared ALU
//   alu_out               result from the shared ALU
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_id       registered result and issuing requester index
//   flush                 discard the pending response, block transfers this cycle
//
// Optional feature macro: ALU_ARB_LOCK_EN (adds req_lock).

package alu_share_pkg;
    localparam int WORD_LEN = 32;

    typedef enum logic [3:0] {
        EXE_ADD = 4'd0,
        EXE_SUB = 4'd1,
        EXE_AND = 4'd2,
        EXE_OR  = 4'd3,
        EXE_XOR = 4'd4,
        EXE_SLL = 4'd5,
        EXE_SRL = 4'd6,
        EXE_SLT = 4'd7
    } execmd_t;
endpackage

module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WORD_LEN-1:0] req_val1,
    input  logic [NUM_REQ*WORD_LEN-1:0] req_val2,
    input  execmd_t                     req_cmd [NUM_REQ],
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          req_lock,
`endif
    output logic [WORD_LEN-1:0]         alu_val1,
    output logic [WORD_LEN-1:0]         alu_val2,
    output execmd_t                     alu_cmd,
    input  logic [WORD_LEN-1:0]         alu_out,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WORD_LEN-1:0]         rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    input  logic                        flush
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [WORD_LEN-1:0]   rsp_data_q, rsp_data_d;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W:0]         cand_sum;
    logic                  can_accept;
    logic                  xfer;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            if (!grant_found && req_valid[cand_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand_sum[ID_W-1:0];
            end
        end
    end

    // The winner drives the ALU even when it cannot be accepted this cycle;
    // the result is simply not captured.
    always_comb begin
        alu_val1 = '0;
        alu_val2 = '0;
        alu_cmd  = EXE_ADD;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_found && (grant_id == ID_W'(k))) begin
                alu_val1 = req_val1[k*WORD_LEN +: WORD_LEN];
                alu_val2 = req_val2[k*WORD_LEN +: WORD_LEN];
                alu_cmd  = req_cmd[k];
            end
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

    // A draining response frees the register in the same cycle, so a new
    // result can be loaded back-to-back.
    assign can_accept = (state_q == ST_EMPTY) || (rsp_valid && rsp_ready);

    always_comb begin
        req_ready = '0;
        if (rst_n && grant_found && can_accept && !flush) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign xfer = |req_ready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else if (xfer) begin
            state_d    = ST_FULL;
            rsp_data_d = alu_out;
            rsp_id_d   = grant_id;
`ifdef ALU_ARB_LOCK_EN
            if (req_lock[grant_id]) begin
                rr_ptr_d = grant_id;
            end else begin
                rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
`else
            rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
`endif
        end else if (rsp_valid && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with an external ALU model
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N   = 4;
    localparam int W   = WORD_LEN;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_val1;
    logic [N*W-1:0]   req_val2;
    execmd_t          req_cmd [N];
`ifdef ALU_ARB_LOCK_EN
    logic [N-1:0]     req_lock;
`endif
    logic [W-1:0]     alu_val1;
    logic [W-1:0]     alu_val2;
    execmd_t          alu_cmd;
    logic [W-1:0]     alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             flush;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_val1  (req_val1),
        .req_val2  (req_val2),
        .req_cmd   (req_cmd),
`ifdef ALU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .alu_val1  (alu_val1),
        .alu_val2  (alu_val2),
        .alu_cmd   (alu_cmd),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .flush     (flush)
    );

    function automatic logic [W-1:0] alu_ref(execmd_t c, logic [W-1:0] a, logic [W-1:0] b);
        case (c)
            EXE_ADD: return a + b;
            EXE_SUB: return a - b;
            EXE_AND: return a & b;
            EXE_OR:  return a | b;
            EXE_XOR: return a ^ b;
            EXE_SLL: return a << b[4:0];
            EXE_SRL: return a >> b[4:0];
            EXE_SLT: return W'($signed(a) < $signed(b));
            default: return '0;
        endcase
    endfunction

    // The shared ALU lives outside the arbiter.
    always_comb alu_out = alu_ref(alu_cmd, alu_val1, alu_val2);

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    bit           mon_en = 1'b0;

    bit           p_valid [N];
    bit           p_lock  [N];
    logic [W-1:0] p_v1    [N];
    logic [W-1:0] p_v2    [N];
    execmd_t      p_cmd   [N];

    int           m_ptr  = 0;
    int           m_g;
    bit           m_xfer;
    int           last_g = -1;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic new_op(int i);
        p_valid[i] = 1'b1;
        p_v1[i]    = $urandom;
        p_v2[i]    = $urandom;
        p_cmd[i]   = execmd_t'(4'($urandom_range(0, 9)));
    endtask

    task automatic set_op(int i, execmd_t c, logic [W-1:0] a, logic [W-1:0] b);
        p_valid[i] = 1'b1;
        p_v1[i]    = a;
        p_v2[i]    = b;
        p_cmd[i]   = c;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0;
            p_lock[i]  = 1'b0;
        end
    endtask

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = p_valid[i];
            req_val1[i*W +: W]   = p_v1[i];
            req_val2[i*W +: W]   = p_v2[i];
            req_cmd[i]           = p_cmd[i];
`ifdef ALU_ARB_LOCK_EN
            req_lock[i]          = p_lock[i];
`endif
        end
    endtask

    // One clock: predict the grant, check req_ready, then commit the model at the edge.
    task automatic tick();
        logic [N-1:0] exp_ready;
        drive_ports();
        #1;
        m_g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (m_g < 0 && p_valid[idx]) m_g = idx;
        end
        m_xfer    = rst_n && !flush && (m_g >= 0) && (exp_q.size() == 0 || rsp_ready);
        exp_ready = '0;
        if (m_xfer) exp_ready[m_g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        last_g = -1;
        if (!rst_n) begin
            exp_q.delete();
            m_ptr = 0;
        end else if (flush) begin
            exp_q.delete();
        end else if (m_xfer) begin
            exp_q.push_back('{m_g, alu_ref(p_cmd[m_g], p_v1[m_g], p_v2[m_g])});
`ifdef ALU_ARB_LOCK_EN
            m_ptr = p_lock[m_g] ? m_g : (m_g + 1) % N;
`else
            m_ptr = (m_g + 1) % N;
`endif
            last_g = m_g;
        end
        #1;
    endtask

    // After an accept, the requester either issues a fresh op or goes idle.
    task automatic retire(bit keep);
        if (last_g >= 0) begin
            if (keep) new_op(last_g);
            else p_valid[last_g] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: compares every presented/drained response against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
            end
        end
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            new_op(i);
            p_lock[i] = 1'b0;
        end

        // Reset held two cycles with every requester valid.
        tick();
        mon_en = 1'b1;
        tick();
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check("first_grant_valid", 64'(rsp_valid), 64'd1);
        check("first_grant_id", 64'(rsp_id), 64'd0);
        clear_all();
        tick();

        // Single op on requester 2.
        do_reset();
        clear_all();
        rsp_ready = 1'b1;
        set_op(2, EXE_SUB, 32'd10, 32'd3);
        drive_ports();
        #1;
        check("single_ready", 64'(req_ready), 64'b0100);
        tick();
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_data", 64'(rsp_data), 64'd7);
        check("single_id", 64'(rsp_id), 64'd2);
        p_valid[2] = 1'b0;
        tick();

        // Round-robin with all requesters busy.
        do_reset();
        clear_all();
        for (int i = 0; i < N; i++) set_op(i, EXE_ADD, W'(i * 100 + 1), W'(i));
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("rr_id", 64'(rsp_id), 64'(order[j]));
            if (j < 4) check("rr_data", 64'(rsp_data), 64'(order[j] * 101 + 1));
            retire(1'b1);
        end
        clear_all();
        tick();

        // Backpressure then drain-and-accept in one cycle.
        do_reset();
        clear_all();
        rsp_ready = 1'b0;
        set_op(0, EXE_ADD, 32'd100, 32'd23);
        tick();
        p_valid[0] = 1'b0;
        set_op(1, EXE_ADD, 32'd5, 32'd6);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_data", 64'(rsp_data), 64'd123);
            check("bp_id", 64'(rsp_id), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_next_data", 64'(rsp_data), 64'd11);
        check("bp_next_id", 64'(rsp_id), 64'd1);
        clear_all();
        tick();

        // Flush discards the pending result and blocks the transfer.
        do_reset();
        clear_all();
        rsp_ready = 1'b0;
        set_op(3, EXE_XOR, 32'hF0F0, 32'h0FF0);
        tick();
        p_valid[3] = 1'b0;
        set_op(1, EXE_OR, 32'h1, 32'h2);
        flush = 1'b1;
        tick();
        check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
        flush = 1'b0;
        tick();
        check("post_flush_id", 64'(rsp_id), 64'd1);
        check("post_flush_data", 64'(rsp_data), 64'd3);
        p_valid[1] = 1'b0;
        set_op(0, EXE_ADD, 32'd1, 32'd1);
        set_op(2, EXE_ADD, 32'd2, 32'd2);
        rsp_ready = 1'b1;
        tick();
        check("post_flush_ptr", 64'(rsp_id), 64'd2);
        clear_all();
        tick();
        tick();

`ifdef ALU_ARB_LOCK_EN
        // Lock keeps requester 0 on top for three consecutive grants.
        do_reset();
        clear_all();
        rsp_ready = 1'b1;
        new_op(0);
        new_op(1);
        p_lock[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) p_lock[0] = 1'b0;
            tick();
            check("lock_id", 64'(rsp_id), 64'd0);
            retire(1'b1);
        end
        tick();
        check("unlock_id", 64'(rsp_id), 64'd1);
        clear_all();
        tick();
`endif

        // Randomized traffic with backpressure, flushes and occasional reset.
        do_reset();
        clear_all();
        for (int c = 0; c < 800; c++) begin
            rsp_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 16) == 0;
            rst_n     = ($urandom % 100) != 0;
            for (int i = 0; i < N; i++) begin
                if (!p_valid[i] && ($urandom % 2 == 0)) new_op(i);
`ifdef ALU_ARB_LOCK_EN
                p_lock[i] = ($urandom % 4) == 0;
`endif
            end
            tick();
            retire(($urandom % 3) != 0);
        end

        rst_n     = 1'b1;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        clear_all();
        tick();
        tick();
        check("final_empty", 64'(rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
